// File: rtl/store_buffer_pkg.sv
// Shared constants and drain FSM encoding for the store buffer.
package store_buffer_pkg;

  localparam int unsigned WORD_OFFSET = 2;
  localparam int unsigned DATA_W      = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match search over the buffered stores for load forwarding.
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 30
) (
  input  logic [TAG_W-1:0]          tags  [DEPTH],
  input  logic [DATA_W-1:0]         datas [DEPTH],
  input  logic [DEPTH-1:0]          valid,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [TAG_W-1:0]          tag,
  output logic                      hit,
  output logic [DATA_W-1:0]         data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (tags[idx] == tag)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer with in-order drain to external memory and load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     memread,
  input  logic [AW-1:0]            addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     stall,
  output logic                     ext_req,
  output logic [AW-1:0]            ext_addr,
  output logic [DATA_W-1:0]        ext_wdata,
  input  logic                     ext_ack,
  output logic [AW-1:0]            ext_raddr,
  input  logic [DATA_W-1:0]        ext_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned TAG_W = AW - WORD_OFFSET;

  logic [TAG_W-1:0]  tags  [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;
  drain_state_t      state;

  logic              full;
  logic              push;
  logic              pop;
  logic              busy;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full       = (count_q == CW'(DEPTH));
  assign push       = memwrite & ~full;
  assign busy       = (state == BUSY);
  assign pop        = busy & ext_ack;
  assign count_next = count_q + CW'(push) - CW'(pop);

  assign stall      = memwrite & full;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign ext_req    = busy;
  assign ext_addr   = busy ? {tags[head], {WORD_OFFSET{1'b0}}} : '0;
  assign ext_wdata  = busy ? datas[head] : '0;
  assign ext_raddr  = addr;
  assign rdata      = (memread && fwd_hit) ? fwd_data : ext_rdata;

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail]  <= addr[AW-1:WORD_OFFSET];
      datas[tail] <= wdata;
    end
  end

  // Pointers, occupancy, valid bits and the drain FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      if (pop) begin
        head        <= head + PW'(1);
        valid[head] <= 1'b0;
      end
      if (push) begin
        tail        <= tail + PW'(1);
        valid[tail] <= 1'b1;
      end
      count_q <= count_next;
      case (state)
        IDLE:    if (count_q != '0) state <= BUSY;
        BUSY:    if (pop && (count_next == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sb_forward_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_forward (
    .tags  (tags),
    .datas (datas),
    .valid (valid),
    .head  (head),
    .tag   (addr[AW-1:WORD_OFFSET]),
    .hit   (fwd_hit),
    .data  (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain handshake, full stall, forwarding, wrap and reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ext_req;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_raddr;
  logic [31:0] ext_rdata;
  logic [2:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .ext_req   (ext_req),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_raddr (ext_raddr),
    .ext_rdata (ext_rdata),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; memread = 1'b0; addr = '0; wdata = '0;
    ext_ack = 1'b0; ext_rdata = '0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_req",   32'(ext_req), 0);
    chk("rst_stall", 32'(stall), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single store, held without ack, then acknowledged.
    memwrite = 1'b1; addr = 32'h10; wdata = 32'hAAAA0001;
    #1 chk("s1_stall", 32'(stall), 0);
    tick();
    memwrite = 1'b0;
    chk("s1_count", 32'(count), 1);
    chk("s1_req_idle", 32'(ext_req), 0);
    tick();
    chk("s1_req", 32'(ext_req), 1);
    chk("s1_wdata", ext_wdata, 32'hAAAA0001);
    for (int i = 0; i < 4; i++) begin
      chk("s1_addr_hold", ext_addr, 32'h10);
      chk("s1_count_hold", 32'(count), 1);
      tick();
    end
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("s1_count_done", 32'(count), 0);
    chk("s1_req_done", 32'(ext_req), 0);
    chk("s1_addr_zero", ext_addr, 0);
    chk("s1_empty", 32'(empty), 1);

    // Fill four entries, fifth stalls until the first ack.
    push(32'h0, 32'h100);
    push(32'h4, 32'h101);
    push(32'h8, 32'h102);
    push(32'hC, 32'h103);
    chk("f_count4", 32'(count), 4);
    memwrite = 1'b1; addr = 32'h30; wdata = 32'h55;
    #1 chk("f_stall", 32'(stall), 1);
    tick();
    chk("f_count_still4", 32'(count), 4);
    ext_ack = 1'b1;
    #1 chk("f_stall_on_ack", 32'(stall), 1);
    tick();
    ext_ack = 1'b0;
    chk("f_count3", 32'(count), 3);
    chk("f_stall_released", 32'(stall), 0);
    tick();
    memwrite = 1'b0;
    chk("f_count_back4", 32'(count), 4);
    ext_ack = 1'b1;
    chk("f_drain0", ext_addr, 32'h4); tick();
    chk("f_drain1", ext_addr, 32'h8); tick();
    chk("f_drain2", ext_addr, 32'hC); tick();
    chk("f_drain3", ext_addr, 32'h30);
    chk("f_drain3_data", ext_wdata, 32'h55); tick();
    ext_ack = 1'b0;
    chk("f_empty", 32'(empty), 1);
    chk("f_req_off", 32'(ext_req), 0);

    // Forwarding picks the youngest of two same-address stores.
    push(32'h20, 32'h11);
    push(32'h20, 32'h22);
    memread = 1'b1; addr = 32'h20; ext_rdata = 32'hDEAD;
    #1 chk("fw_young", rdata, 32'h22);
    addr = 32'h24;
    #1 chk("fw_miss", rdata, 32'hDEAD);
    memread = 1'b0; addr = 32'h20;
    #1 chk("fw_noread", rdata, 32'hDEAD);
    ext_ack = 1'b1;
    chk("fw_order0", ext_wdata, 32'h11); tick();
    chk("fw_order1", ext_wdata, 32'h22); tick();
    ext_ack = 1'b0;
    chk("fw_empty", 32'(count), 0);

    // Three entries, then push+ack together; six pushes wrap the tail.
    push(32'h100, 32'h1);
    push(32'h104, 32'h2);
    push(32'h108, 32'h3);
    chk("w_count3", 32'(count), 3);
    ext_ack = 1'b1;
    chk("w_head0", ext_addr, 32'h100); push(32'h10C, 32'h4);
    chk("w_pp_count", 32'(count), 3);
    chk("w_head1", ext_addr, 32'h104); push(32'h110, 32'h5);
    chk("w_head2", ext_addr, 32'h108); push(32'h114, 32'h6);
    ext_ack = 1'b0;
    chk("w_count_after", 32'(count), 3);
    memread = 1'b1; addr = 32'h110;
    #1 chk("w_fwd_wrapped", rdata, 32'h5);
    memread = 1'b0;
    ext_ack = 1'b1;
    chk("w_drain0", ext_addr, 32'h10C); tick();
    chk("w_drain1", ext_addr, 32'h110); tick();
    chk("w_drain2", ext_addr, 32'h114); tick();
    ext_ack = 1'b0;
    chk("w_empty", 32'(empty), 1);

    // Reset while draining discards everything; later ack is ignored.
    push(32'h200, 32'h7);
    push(32'h204, 32'h8);
    chk("r_busy", 32'(ext_req), 1);
    chk("r_count2", 32'(count), 2);
    reset = 1'b1;
    memwrite = 1'b1; addr = 32'h208;
    #1;
    chk("r_req_async", 32'(ext_req), 0);
    chk("r_count_async", 32'(count), 0);
    chk("r_empty_async", 32'(empty), 1);
    chk("r_stall_async", 32'(stall), 0);
    memwrite = 1'b0;
    tick();
    reset = 1'b0;
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("r_ack_ignored", 32'(count), 0);
    tick();
    chk("r_req_stays", 32'(ext_req), 0);

    // Load the cycle after a store sees the buffered data.
    push(32'h40, 32'h5);
    memread = 1'b1; addr = 32'h40; ext_rdata = 32'hDEAD;
    #1 chk("n_fwd", rdata, 32'h5);
    chk("n_raddr", ext_raddr, 32'h40);
    memread = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; asynchronous and active-high.
REQ-005 memwrite  input  1  datapath store request this cycle.
REQ-006 memread  input  1  datapath load request this cycle.
REQ-007 addr  input  AW  byte address from the ALU result; bits [1:0] ignored (word access).
REQ-008 wdata  input  32  store data (register-file second read port).
REQ-009 rdata  output  32  load data returned to the datapath write-back mux.
REQ-010 stall  output  1  store not accepted this cycle; the CPU holds PC and does not retire.
REQ-011 ext_req  output  1  drain request to the external data memory.
REQ-012 ext_addr  output  AW  address of the drained store.
REQ-013 ext_wdata  output  32  data of the drained store.
REQ-014 ext_ack  input  1  external memory has accepted the drained store.
REQ-015 ext_raddr  output  AW  combinational read address to the external memory; equals addr.
REQ-016 ext_rdata  input  32  combinational read data from the external memory.
REQ-017 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Entries form a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-020 full = (count == DEPTH), computed from registered count only.
REQ-021 stall = memwrite & full; combinational; zero-cycle latency.
REQ-022 Push when memwrite & !full: {addr, wdata} written at tail, tail advances at the next edge.
REQ-023 Drain FSM states: IDLE, BUSY.
REQ-024 IDLE -> BUSY at the edge where count != 0; ext_req = 1 exactly in BUSY.
REQ-025 In BUSY, ext_addr and ext_wdata equal the head entry and stay stable until acknowledged.
REQ-026 In BUSY with ext_ack = 1: head pops at that edge; BUSY is kept if entries remain after the pop, otherwise -> IDLE.
REQ-027 ext_ack in IDLE is ignored.
REQ-028 Push and pop in the same cycle leave count unchanged; a push when full is refused even if a pop occurs that cycle.
REQ-029 When ext_req = 0, ext_addr and ext_wdata drive 0.
REQ-030 Load forwarding: when memread = 1, addr[AW-1:2] is compared against every valid entry. The youngest match supplies rdata; with no match, rdata = ext_rdata. Combinational.
REQ-031 Forwarding uses pre-edge buffer contents; a same-cycle push is not visible.
REQ-032 memread & memwrite in the same cycle is illegal; the store is still processed per REQ-022.
REQ-033 When memread = 0, rdata = ext_rdata.
REQ-034 Stores to the same address are not coalesced; each store drains individually, in program order.

Reset
REQ-035 Asserting reset immediately clears head, tail and count to 0, all valid bits to 0, and the FSM to IDLE; ext_req = 0, empty = 1 and stall = 0 without waiting for a clock edge.
REQ-036 Reset during BUSY abandons the in-flight store and discards all buffered stores; a later ext_ack is ignored.
REQ-037 Entry data storage need not be reset.

Structure
REQ-038 The shared package holds the FSM state encoding (IDLE = 0, BUSY = 1) and the word-offset constant 2.
REQ-039 The youngest-match forwarding logic is one sub-module, sb_forward_match, which takes the entry array, valid bits and head pointer and returns hit and data.
REQ-040 The FIFO storage is inferred as a register array; no memory macro is used.

Verification
REQ-041 Store 0xAAAA0001 to 0x10, ext_ack held 0 for 5 cycles -> ext_req = 1 from the next cycle, ext_addr = 0x10 stable; count = 1 until the ack, then 0 and back to IDLE.
REQ-042 Four stores to 0x0, 0x4, 0x8, 0xC with no ack, then a fifth store -> stall = 1 on the fifth; count = 4; the fifth store is accepted the cycle after the first ack.
REQ-043 Stores 0x11 then 0x22 to 0x20, then a load from 0x20 with ext_rdata = 0xDEAD -> rdata = 0x22; a load from 0x24 -> rdata = 0xDEAD.
REQ-044 Buffer holding 3 entries, push and ack in the same cycle -> count stays 3; wrap-around of tail from 3 to 0 is checked after 6 pushes.
REQ-045 Reset asserted mid-BUSY with 2 entries -> ext_req = 0 and count = 0 before the next edge; an ext_ack pulse afterwards changes nothing.
REQ-046 Load to 0x40 in the same cycle as a store to 0x40 is excluded; a load to 0x40 in the cycle after a store of 0x5 to 0x40 -> rdata = 0x5.
